// File: rtl/sha3_absorb_packer_if.sv
// Bus bundle between the cust5 word source, the absorb packer and the Keccak core.
// Both handshakes transfer on the rising edge where valid && ready; valid never waits on ready.
interface sha3_absorb_packer_if #(
    parameter int RATE_WORDS = 18
);
    logic                       in_valid;
    logic                       in_ready;
    logic [2:0]                 in_op;
    logic [31:0]                in_word;
    logic [1:0]                 in_nbytes;
    logic                       blk_valid;
    logic                       blk_ready;
    logic [RATE_WORDS*32-1:0]   blk_data;
    logic                       blk_last;
    logic                       msg_active;
    logic                       err;

    modport master (
        output in_valid, in_op, in_word, in_nbytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last, msg_active, err
    );

    modport slave (
        input  in_valid, in_op, in_word, in_nbytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last, msg_active, err
    );
endinterface

// File: rtl/sha3_absorb_packer.sv
// Packs the cust5 32-bit message stream into SHA3 rate blocks, applies 0x06..0x80
// padding on the tail word and holds each block until the permutation core takes it.
module sha3_absorb_packer #(
    parameter int          RATE_WORDS = 18,
    parameter logic [7:0]  PAD_FIRST  = 8'h06,
    parameter logic [7:0]  PAD_LAST   = 8'h80
) (
    input  logic                 clk,
    input  logic                 rst,
    sha3_absorb_packer_if.slave  bus,
    output logic [1:0]           dbg_state_o
);
    localparam int BLK_W = RATE_WORDS * 32;
    localparam int CW    = $clog2(RATE_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BLK_W-1:0]  buf_q, buf_d;
    logic              last_q, last_d;
    logic              active_q, active_d;
    logic              err_q, err_d;

    logic              accept;
    logic              op_head, op_body, op_tail, op_bad;
    logic [31:0]       tail_word;
    int                wr_base;

    assign op_head = (bus.in_op == 3'b100);
    assign op_body = (bus.in_op == 3'b010);
    assign op_tail = (bus.in_op == 3'b001);
    assign op_bad  = !(op_head || op_body || op_tail);
    assign accept  = bus.in_valid && (state_q != S_HOLD);

    // Keep the k leading message bytes, put the domain byte right after them, zero the rest.
    always_comb begin
        tail_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(bus.in_nbytes)) begin
                tail_word[31-8*b -: 8] = bus.in_word[31-8*b -: 8];
            end else if (b == int'(bus.in_nbytes)) begin
                tail_word[31-8*b -: 8] = PAD_FIRST;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        last_d   = last_q;
        active_d = active_q;
        err_d    = err_q;
        wr_base  = 0;
        if (cnt_q < CW'(RATE_WORDS)) begin
            wr_base = (RATE_WORDS - 1 - int'(cnt_q)) * 32;
        end

        case (state_q)
            S_HOLD: begin
                if (bus.blk_ready) begin
                    buf_d  = '0;
                    cnt_d  = '0;
                    last_d = 1'b0;
                    if (last_q) begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end else begin
                        state_d  = S_FILL;
                    end
                end
            end
            default: begin
                if (accept) begin
                    if (op_bad) begin
                        err_d = 1'b1;
                    end else if (op_head) begin
                        // A head in FILL simply restarts: the partial block is never emitted.
                        buf_d                 = '0;
                        buf_d[BLK_W-1 -: 32]  = bus.in_word;
                        cnt_d                 = CW'(1);
                        active_d              = 1'b1;
                        err_d                 = 1'b0;
                        state_d               = S_FILL;
                    end else if (state_q == S_IDLE) begin
                        err_d = 1'b1;
                    end else if (op_body) begin
                        buf_d[wr_base +: 32] = bus.in_word;
                        cnt_d                = cnt_q + CW'(1);
                        if (cnt_q == CW'(RATE_WORDS - 1)) begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        buf_d[wr_base +: 32] = tail_word;
                        buf_d[7:0]           = buf_d[7:0] | PAD_LAST;
                        last_d               = 1'b1;
                        state_d              = S_HOLD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            buf_q    <= '0;
            last_q   <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            last_q   <= last_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready   = (state_q != S_HOLD);
    assign bus.blk_valid  = (state_q == S_HOLD);
    assign bus.blk_data   = buf_q;
    assign bus.blk_last   = last_q;
    assign bus.msg_active = active_q;
    assign bus.err        = err_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_sha3_absorb_packer.sv
// Bench for sha3_absorb_packer: byte-list reference model, per-cycle compare process,
// directed scenarios pinned with literal block contents and a randomized message run.
module tb_sha3_absorb_packer;
    localparam logic [2:0] OP_HEAD = 3'b100;
    localparam logic [2:0] OP_BODY = 3'b010;
    localparam logic [2:0] OP_TAIL = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dbg_state;

    sha3_absorb_packer_if #(.RATE_WORDS(18)) bus();

    sha3_absorb_packer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;
    bit auto_rdy  = 1'b1;
    bit rdy_force = 1'b0;

    // Reference model state: the bytes of the block being filled, plus pending blocks.
    logic [7:0]   cur_q[$];
    logic [575:0] exp_q[$];
    logic         exp_last_q[$];
    logic [575:0] cap_q[$];
    logic         cap_last_q[$];
    bit           m_act  = 1'b0;
    bit           m_err  = 1'b0;
    bit           m_pend = 1'b0;
    bit           m_last = 1'b0;

    task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        total_cnt++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic logic [31:0] wd(input logic [575:0] b, input int i);
        return b[575-32*i -: 32];
    endfunction

    task automatic push_bytes(input logic [31:0] w, input int k);
        for (int i = 0; i < k; i++) cur_q.push_back(w[31-8*i -: 8]);
    endtask

    task automatic emit(input bit l);
        logic [575:0] b;
        for (int i = 0; i < 72; i++) b[575-8*i -: 8] = cur_q[i];
        exp_q.push_back(b);
        exp_last_q.push_back(l);
        cur_q.delete();
        m_pend = 1'b1;
        m_last = l;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_last = 1'b0;
            cur_q.delete(); exp_q.delete(); exp_last_q.delete();
        end else if (m_pend) begin
            if (bus.blk_ready) begin
                m_pend = 1'b0;
                if (m_last) m_act = 1'b0;
                m_last = 1'b0;
            end
        end else if (bus.in_valid) begin
            case (bus.in_op)
                OP_HEAD: begin
                    cur_q.delete();
                    push_bytes(bus.in_word, 4);
                    m_act = 1'b1;
                    m_err = 1'b0;
                end
                OP_BODY: begin
                    if (!m_act) m_err = 1'b1;
                    else begin
                        push_bytes(bus.in_word, 4);
                        if (cur_q.size() == 72) emit(1'b0);
                    end
                end
                OP_TAIL: begin
                    if (!m_act) m_err = 1'b1;
                    else begin
                        push_bytes(bus.in_word, int'(bus.in_nbytes));
                        cur_q.push_back(8'h06);
                        while (cur_q.size() < 72) cur_q.push_back(8'h00);
                        cur_q[71] = cur_q[71] | 8'h80;
                        emit(1'b1);
                    end
                end
                default: m_err = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (auto_rdy) bus.blk_ready = ($urandom_range(0, 3) != 0);
        else          bus.blk_ready = rdy_force;
    end

    // Compare process: runs mid-cycle while all DUT outputs are settled.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            chk("in_ready", bus.in_ready, !m_pend);
            chk("blk_valid", bus.blk_valid, m_pend);
            chk("msg_active", bus.msg_active, m_act);
            chk("err", bus.err, m_err);
            if (bus.blk_valid) begin
                if (exp_q.size() == 0) fail_now("blk_unexpected");
                else begin
                    chk("blk_data", bus.blk_data, exp_q[0]);
                    chk("blk_last", bus.blk_last, exp_last_q[0]);
                    if (bus.blk_ready) begin
                        void'(exp_q.pop_front());
                        void'(exp_last_q.pop_front());
                        cap_q.push_back(bus.blk_data);
                        cap_last_q.push_back(bus.blk_last);
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] w, input logic [1:0] nb);
        logic r;
        int   n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_word = w; bus.in_nbytes = nb;
        forever begin
            #1 r = bus.in_ready;
            @(posedge clk);
            if (r) break;
            n++;
            if (n > 200) begin fail_now("send_wait"); break; end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_blk(output logic [575:0] b, output logic l);
        int n = 0;
        b = '0; l = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        while (cap_q.size() == 0 && n < 100) begin
            @(negedge clk); #2; n++;
        end
        if (cap_q.size() == 0) fail_now("wait_blk");
        else begin
            b = cap_q.pop_front();
            l = cap_last_q.pop_front();
        end
    endtask

    logic [31:0]  fox[11];
    logic [575:0] blk, held;
    logic         lst;

    initial begin
        fox = '{"The ", "quic", "k br", "own ", "fox ", "jump",
                "s ov", "er t", "he l", "azy ", "dog."};
        bus.in_valid = 1'b0; bus.in_op = 3'b000; bus.in_word = '0; bus.in_nbytes = '0;
        #1 rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_blk_valid", bus.blk_valid, 1'b0);
        chk("rst_blk_last", bus.blk_last, 1'b0);
        chk("rst_msg_active", bus.msg_active, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_blk_data", bus.blk_data, '0);
        @(negedge clk) rst = 1'b0;
        chk_en = 1'b1;

        // Body before any head: error, no block; a head then recovers.
        send(OP_BODY, 32'hDEAD_BEEF, 2'd0);
        idle(1); #1;
        chk("err_set", bus.err, 1'b1);
        chk("err_no_blk", bus.blk_valid, 1'b0);
        send(OP_HEAD, "abcd", 2'd0);
        idle(1); #1;
        chk("err_cleared", bus.err, 1'b0);
        chk("err_active", bus.msg_active, 1'b1);
        send(OP_TAIL, 32'h1234_5678, 2'd0);
        wait_blk(blk, lst);
        chk("err_w0", wd(blk, 0), "abcd");
        chk("err_w1", wd(blk, 1), 32'h0600_0000);
        chk("err_w17", wd(blk, 17), 32'h0000_0080);

        // Fox message, tail with no bytes.
        send(OP_HEAD, fox[0], 2'd0);
        for (int i = 1; i < 11; i++) send(OP_BODY, fox[i], 2'($urandom_range(0, 3)));
        send(OP_TAIL, 32'hFFFF_FFFF, 2'd0);
        wait_blk(blk, lst);
        chk("fox_last", lst, 1'b1);
        for (int i = 0; i < 11; i++) chk("fox_msg", wd(blk, i), fox[i]);
        chk("fox_w11", wd(blk, 11), 32'h0600_0000);
        for (int i = 12; i < 17; i++) chk("fox_zero", wd(blk, i), 32'h0);
        chk("fox_w17", wd(blk, 17), 32'h0000_0080);

        // Tail of 3 bytes in the final word: pad bytes merge into 0x86.
        send(OP_HEAD, 32'h0101_0101, 2'd0);
        for (int i = 1; i < 17; i++) send(OP_BODY, 32'h0202_0202, 2'd0);
        send(OP_TAIL, 32'h4142_43EE, 2'd3);
        wait_blk(blk, lst);
        chk("t17_last", lst, 1'b1);
        chk("t17_w17", wd(blk, 17), 32'h4142_4386);
        chk("t17_w16", wd(blk, 16), 32'h0202_0202);

        // Exactly full block, then padding-only block.
        send(OP_HEAD, 32'hA5A5_A5A5, 2'd0);
        for (int i = 1; i < 18; i++) send(OP_BODY, 32'hA5A5_A5A5, 2'd0);
        send(OP_TAIL, 32'h0, 2'd0);
        wait_blk(blk, lst);
        chk("a5_b1", blk, {18{32'hA5A5_A5A5}});
        chk("a5_b1_last", lst, 1'b0);
        wait_blk(blk, lst);
        chk("a5_b2_w0", wd(blk, 0), 32'h0600_0000);
        chk("a5_b2_w1", wd(blk, 1), 32'h0);
        chk("a5_b2_w17", wd(blk, 17), 32'h0000_0080);
        chk("a5_b2_last", lst, 1'b1);

        // Backpressure: core stalls for 5 cycles with a word waiting upstream.
        auto_rdy = 1'b0; rdy_force = 1'b0;
        send(OP_HEAD, 32'h0, 2'd0);
        for (int i = 1; i < 18; i++) send(OP_BODY, i, 2'd0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = OP_BODY; bus.in_word = 32'h1111_1111;
        #1 held = bus.blk_data;
        chk("bp_valid", bus.blk_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_stable", bus.blk_data, held);
        end
        @(posedge clk); #1 rdy_force = 1'b1;
        @(posedge clk); #1 rdy_force = 1'b0;
        @(posedge clk);
        send(OP_TAIL, 32'h0, 2'd0);
        auto_rdy = 1'b1;
        wait_blk(blk, lst);
        chk("bp_b1_w5", wd(blk, 5), 32'd5);
        chk("bp_b1_last", lst, 1'b0);
        wait_blk(blk, lst);
        chk("bp_b2_w0", wd(blk, 0), 32'h1111_1111);
        chk("bp_b2_w1", wd(blk, 1), 32'h0600_0000);
        chk("bp_b2_last", lst, 1'b1);

        // Reset in the middle of a message.
        send(OP_HEAD, 32'h5555_5555, 2'd0);
        for (int i = 1; i < 6; i++) send(OP_BODY, 32'h6666_6666, 2'd0);
        #1 rst = 1'b1;
        #1;
        chk("mrst_in_ready", bus.in_ready, 1'b1);
        chk("mrst_blk_valid", bus.blk_valid, 1'b0);
        chk("mrst_blk_last", bus.blk_last, 1'b0);
        chk("mrst_msg_active", bus.msg_active, 1'b0);
        chk("mrst_err", bus.err, 1'b0);
        chk("mrst_blk_data", bus.blk_data, '0);
        idle(1);
        @(negedge clk) rst = 1'b0;
        chk("mrst_no_blk", 576'(cap_q.size()), 576'd0);
        send(OP_HEAD, "wxyz", 2'd0);
        send(OP_TAIL, 32'h0, 2'd0);
        wait_blk(blk, lst);
        chk("mrst_w0", wd(blk, 0), "wxyz");
        chk("mrst_w1", wd(blk, 1), 32'h0600_0000);

        // Randomized messages with aborts, bad opcodes and stray bodies.
        for (int m = 0; m < 25; m++) begin
            if ($urandom_range(0, 9) == 0) send(OP_BODY, $urandom, 2'd0);
            send(OP_HEAD, $urandom, 2'($urandom_range(0, 3)));
            for (int b = 0, nb = $urandom_range(0, 40); b < nb; b++) begin
                case ($urandom_range(0, 29))
                    0: send(3'b000, $urandom, 2'd0);
                    1: send(3'b011, $urandom, 2'd0);
                    2: send(3'b111, $urandom, 2'd0);
                    3: send(OP_HEAD, $urandom, 2'd0);
                    default: send(OP_BODY, $urandom, 2'($urandom_range(0, 3)));
                endcase
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
            end
            send(OP_TAIL, $urandom, 2'($urandom_range(0, 3)));
        end
        begin
            int n = 0;
            idle(1);
            while ((m_pend || exp_q.size() != 0) && n < 200) begin
                @(negedge clk); n++;
            end
            if (m_pend || exp_q.size() != 0) fail_now("drain");
        end
        idle(2);
        cap_q.delete();
        cap_last_q.delete();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sha3_absorb_packer.md
Name: sha3_absorb_packer

Overview:
- Upstream stage of the SHA3-512 cust5 datapath.
- Accepts the 32-bit message word stream issued by l.cust5 HEAD/BODY/TAIL ops and packs it into 576-bit rate blocks (18 words).
- Applies SHA3 padding (0x06 … 0x80) and hands each block to the Keccak permutation core over a valid/ready handshake.
- Unchanged byte order: byte 0 of the message is in_word[31:24]. Any lane byte reversal is done by the permutation core.

Parameters:
- RATE_WORDS, 18, words per rate block (576 bits for SHA3-512).
- PAD_FIRST, 8'h06, domain/pad byte written directly after the last message byte.
- PAD_LAST, 8'h80, byte OR-ed into the final byte of the final block.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  word strobe from cust5 ALU path.
- in_ready  output  1  packer can accept a word this cycle.
- in_op  input  3  one-hot {head, body, tail}, matching cust5_op[2:0]: 3'b100 head, 3'b010 body, 3'b001 tail.
- in_word  input  32  message word (big-endian bytes within the word).
- in_nbytes  input  2  valid bytes in a tail word (0..3, taken from [31:24] downward). Ignored for head/body.
- blk_valid  output  1  rate block available.
- blk_ready  input  1  permutation core accepts the block.
- blk_data  output  576  word 0 at [575:544], word 17 at [31:0].
- blk_last  output  1  block is the padded final block of the message.
- msg_active  output  1  a message is open (head seen, tail not yet processed).
- err  output  1  sticky protocol error; cleared only by rst or an accepted head.

Behaviour:
- Reset (async):
  - Outputs: in_ready=1, blk_valid=0, blk_last=0, msg_active=0, err=0, blk_data=0.
  - Internal: word counter=0, state=IDLE.
- States: IDLE, FILL, HOLD.
  - IDLE→FILL on accepted head.
  - FILL→HOLD when the RATE_WORDS-th word is written, or when a tail is accepted.
  - HOLD→FILL on blk_valid&&blk_ready if the block was not last.
  - HOLD→IDLE on blk_valid&&blk_ready if the block was last.
- Accept condition: in_valid && in_ready. in_ready = (state != HOLD).
- Head:
  - Clears the buffer and word counter, then writes in_word as word 0.
  - Sets msg_active=1 and clears err.
  - A head accepted in FILL aborts the open message. The partial block is discarded and not emitted.
- Body: writes in_word at the counter position; counter increments.
- Full block:
  - When the counter reaches RATE_WORDS, blk_valid=1 and blk_last=0 on the next cycle.
  - The counter and buffer clear on handoff.
- Tail (k = in_nbytes):
  - Write the k upper bytes of in_word, then PAD_FIRST at byte position k, then zeros through the end of the block.
  - OR PAD_LAST into byte 71, which is blk_data[7:0].
  - If PAD_FIRST lands in byte 71 (counter=17, k=3), that byte is 8'h86.
  - blk_valid=1 and blk_last=1 on the next cycle. msg_active drops when the last block is handed off.
  - Padding always fits in the current block: a full block is emitted before any tail can be accepted, and a tail carries at most 3 bytes.
- Latency: one cycle from the accepting edge to blk_valid.
- HOLD:
  - blk_data and blk_last are stable until handoff.
  - The cycle after handoff, blk_valid=0 and in_ready=1.
- Errors (word dropped, err set, state unchanged):
  - body or tail in IDLE;
  - in_op not one-hot, including 0.
- Words with in_valid=0 are ignored regardless of in_op.
- blk_ready is ignored when blk_valid=0.
- Reset asserted mid-message or in HOLD discards everything immediately; no block is emitted.

Test Plan:
- Fox message: head "The ", body "quic" … "dog." (11 words total), then tail in_nbytes=0.
  - One block with blk_last=1.
  - Words 0-10 = the ASCII message.
  - Word 11 = 32'h0600_0000.
  - Words 12-16 = 0.
  - Word 17 = 32'h0000_0080.
- Tail at counter=17 with in_word=32'h4142_43xx, in_nbytes=3 → word 17 = 32'h4142_4386, blk_last=1.
- Head plus 17 body words of 32'hA5A5_A5A5, then tail in_nbytes=0:
  - Block 1: all words A5A5A5A5, blk_last=0.
  - Block 2: word 0 = 32'h0600_0000, word 17 = 32'h0000_0080, blk_last=1.
- Backpressure: hold blk_ready=0 for 5 cycles after a full block.
  - in_ready=0 and blk_data is stable throughout.
  - A word presented during the hold is not taken.
  - After blk_ready=1, the next word lands as word 0.
- Body before any head → err=1, no block emitted. A following head clears err, and the normal flow resumes.
- Assert rst after 6 words → all outputs return to reset values within the same cycle. A fresh head then tail (nbytes=0) gives word 1 = 32'h0600_0000.
